fuzz_vector_sequencer: RTL and testbench
========================================

Name: fuzz_vector_sequencer

Overview:
- Replays a stored list of input vectors into a fuzzed `top` netlist and its golden reference model.
- Samples both 82-bit `y` outputs once per vector, compares them, and folds the DUT output into a 32-bit MISR signature.
- Sits between the regression controller and the DUT pair, so the clock-strobed checking normally done in a testbench becomes self-checking hardware.

Parameters:
- VEC_W, 53: concatenated DUT input width, packed {wire4[10:0], wire3[8:0], wire2[9:0], wire1[11:0], wire0[10:0]}.
- Y_W, 82: DUT output width.
- DEPTH, 32: vector memory entries.
- AW, 5: address width, log2(DEPTH).
- HOLD, 2: cycles each vector is held before sampling; must be at least 1.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous, active-low reset.
- cfg_we, input, 1: vector memory write strobe.
- cfg_addr, input, AW: write address.
- cfg_wdata, input, VEC_W: vector to store.
- cfg_num, input, AW+1: number of vectors to run; sampled at start.
- start, input, 1: begin a run; single-cycle pulse.
- stim, output, VEC_W: registered drive to both DUT copies.
- y_ref, input, Y_W: golden model output.
- y_dut, input, Y_W: synthesized netlist output.
- busy, output, 1: high while a run is in progress.
- done, output, 1: level; set at the end of a run, cleared by the next accepted start.
- mismatch, output, 1: sticky for the current run; high if any compare failed.
- mismatch_idx, output, AW: index of the first failing vector.
- mismatch_count, output, AW+1: number of failing vectors.
- signature, output, 32: MISR value over the sampled y_dut.

Behaviour:
- Reset (async assert, sync deassert):
  - Outputs go to zero: stim, busy, done, mismatch, mismatch_idx, mismatch_count and signature = 0.
  - FSM returns to IDLE.
  - Vector memory is not reset; contents survive reset.
- FSM states: IDLE, ZERO, APPLY, DONE. A hold counter hc is loaded with HOLD-1 on entering ZERO or APPLY.
- IDLE:
  - cfg_we writes mem[cfg_addr] = cfg_wdata.
  - start accepted → ZERO on the same edge. At that edge:
    - latch n = min(cfg_num, DEPTH);
    - clear done, mismatch, mismatch_idx, mismatch_count and signature;
    - set busy = 1 and stim = 0;
    - idx = 0.
- ZERO:
  - Settling phase with all DUT inputs at zero.
  - When hc == 0: if n == 0 → DONE; else → APPLY with stim = mem[0].
  - Otherwise hc decrements.
- APPLY:
  - stim holds mem[idx] for HOLD cycles.
  - At the edge where hc == 0, sample y_ref and y_dut:
    - If y_ref != y_dut: mismatch_count increments. If this is the first mismatch, set mismatch_idx = idx and mismatch = 1.
    - signature = {sig[30:0], sig[31]^sig[21]^sig[1]^sig[0]} XOR fold(y_dut).
    - fold = y_dut[31:0] ^ y_dut[63:32] ^ {14'b0, y_dut[81:64]}.
  - Same edge: if idx == n-1 → DONE with stim = 0; else idx++ and stim = mem[idx+1].
- DONE: busy = 0, done = 1; go to IDLE on the next edge. done stays high until the next accepted start.
- Run length: the first APPLY starts HOLD cycles after the start edge. busy is high for HOLD*(n+1) cycles.
- Ignored inputs:
  - start while busy is ignored; no restart.
  - cfg_we while busy is ignored; the memory is stable during a run.
  - start and cfg_we in the same IDLE cycle: the write happens and the run starts. Whether that write is visible to mem[0] depends on the read port, so the bench must not rely on it.
- mismatch_count never exceeds DEPTH, so no saturation logic is needed.
- Reset mid-run: aborts immediately. done stays 0. A later start runs normally using the retained memory contents.

Test Plan:
- Reset: rst_n = 0 with nonzero inputs → all outputs 0 and busy = 0. Release reset, pulse start with cfg_num = 0 → busy for 2 cycles, then done = 1, signature = 0, mismatch = 0.
- Clean run: load mem[0..2] = 53'h1, 53'h2, 53'h3, cfg_num = 3, y_ref = y_dut = 0, pulse start at edge E0:
  - stim = 0 for E0–E1, 1 for E2–E3, 2 for E4–E5, 3 for E6–E7;
  - done = 1 at E8;
  - mismatch = 0, signature = 0.
- Single mismatch: same setup, force y_dut = y_ref ^ 82'h1 only while stim == 2 → mismatch = 1, mismatch_idx = 1, mismatch_count = 1.
- Signature: cfg_num = 2, y_dut = y_ref = 82'h1 constant → signature 0x1 after the first sample and 0x2 after the second.
- Robustness:
  - start pulsed during APPLY → stim sequence unchanged;
  - cfg_we to address 1 during the run → memory unchanged;
  - cfg_num = 40 → exactly 32 vectors are applied.
- Reset mid-run: rst_n low while stim = mem[1] → stim = 0, busy = 0, done = 0 immediately. A new start replays mem[0..n-1] and the signature matches the clean-run value.

Source files
------------

// File: rtl/fuzz_vector_sequencer_if.sv
// Bus between the regression controller / DUT pair and the vector sequencer.
// master: drives config, start and DUT outputs; slave: drives stim and results.
interface fuzz_vector_sequencer_if #(
    parameter int VEC_W = 53,
    parameter int Y_W   = 82,
    parameter int AW    = 5
);
    logic             cfg_we;
    logic [AW-1:0]    cfg_addr;
    logic [VEC_W-1:0] cfg_wdata;
    logic [AW:0]      cfg_num;
    logic             start;
    logic [VEC_W-1:0] stim;
    logic [Y_W-1:0]   y_ref;
    logic [Y_W-1:0]   y_dut;
    logic             busy;
    logic             done;
    logic             mismatch;
    logic [AW-1:0]    mismatch_idx;
    logic [AW:0]      mismatch_count;
    logic [31:0]      signature;

    modport master (
        output cfg_we, cfg_addr, cfg_wdata, cfg_num, start,
        output y_ref, y_dut,
        input  stim, busy, done, mismatch,
        input  mismatch_idx, mismatch_count, signature
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_wdata, cfg_num, start,
        input  y_ref, y_dut,
        output stim, busy, done, mismatch,
        output mismatch_idx, mismatch_count, signature
    );
endinterface

// File: rtl/fuzz_vector_sequencer.sv
// Replays stored vectors into a DUT/reference pair, compares y, builds a MISR.
// Ports: clk, rst_n (async active-low), bus (slave side of the sequencer bus).
module fuzz_vector_sequencer #(
    parameter int VEC_W = 53,
    parameter int Y_W   = 82,
    parameter int DEPTH = 32,
    parameter int AW    = 5,
    parameter int HOLD  = 2
) (
    input logic                   clk,
    input logic                   rst_n,
    fuzz_vector_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ZERO, APPLY, DONE} state_t;

    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HW-1:0] HC_INIT = HW'(HOLD - 1);
    localparam logic [AW:0]   DEPTH_N = (AW + 1)'(DEPTH);

    state_t           state, state_n;
    logic [HW-1:0]    hc, hc_n;
    logic [AW-1:0]    idx, idx_n;
    logic [AW:0]      n, n_n;
    logic [VEC_W-1:0] stim, stim_n;
    logic             busy, busy_n;
    logic             done, done_n;
    logic             mis, mis_n;
    logic [AW-1:0]    midx, midx_n;
    logic [AW:0]      mcnt, mcnt_n;
    logic [31:0]      sig, sig_n;

    logic [VEC_W-1:0] mem [DEPTH];
    logic [31:0]      fold;
    logic [31:0]      sig_step;
    logic [AW-1:0]    idx_inc;
    logic             last;

    assign fold = bus.y_dut[31:0] ^ bus.y_dut[63:32]
                ^ {14'b0, bus.y_dut[81:64]};
    assign sig_step = {sig[30:0], sig[31] ^ sig[21] ^ sig[1] ^ sig[0]}
                    ^ fold;
    assign idx_inc = idx + AW'(1);
    // n is at least 1 whenever APPLY is reached
    assign last = ({1'b0, idx} == n - (AW + 1)'(1));

    // Memory is deliberately outside reset so vectors survive a reset
    always_ff @(posedge clk) begin
        if (rst_n && state == IDLE && bus.cfg_we)
            mem[bus.cfg_addr] <= bus.cfg_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            hc    <= '0;
            idx   <= '0;
            n     <= '0;
            stim  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            mis   <= 1'b0;
            midx  <= '0;
            mcnt  <= '0;
            sig   <= '0;
        end else begin
            state <= state_n;
            hc    <= hc_n;
            idx   <= idx_n;
            n     <= n_n;
            stim  <= stim_n;
            busy  <= busy_n;
            done  <= done_n;
            mis   <= mis_n;
            midx  <= midx_n;
            mcnt  <= mcnt_n;
            sig   <= sig_n;
        end
    end

    always_comb begin
        state_n = state;
        hc_n    = hc;
        idx_n   = idx;
        n_n     = n;
        stim_n  = stim;
        busy_n  = busy;
        done_n  = done;
        mis_n   = mis;
        midx_n  = midx;
        mcnt_n  = mcnt;
        sig_n   = sig;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_n = ZERO;
                    hc_n    = HC_INIT;
                    n_n     = (bus.cfg_num > DEPTH_N) ? DEPTH_N
                                                      : bus.cfg_num;
                    idx_n   = '0;
                    stim_n  = '0;
                    busy_n  = 1'b1;
                    done_n  = 1'b0;
                    mis_n   = 1'b0;
                    midx_n  = '0;
                    mcnt_n  = '0;
                    sig_n   = '0;
                end
            end
            ZERO: begin
                if (hc == '0) begin
                    if (n == '0) begin
                        state_n = DONE;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                    end else begin
                        state_n = APPLY;
                        hc_n    = HC_INIT;
                        stim_n  = mem[0];
                    end
                end else begin
                    hc_n = hc - HW'(1);
                end
            end
            APPLY: begin
                if (hc == '0) begin
                    sig_n = sig_step;
                    if (bus.y_ref != bus.y_dut) begin
                        mcnt_n = mcnt + (AW + 1)'(1);
                        if (!mis) begin
                            mis_n  = 1'b1;
                            midx_n = idx;
                        end
                    end
                    if (last) begin
                        state_n = DONE;
                        stim_n  = '0;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                    end else begin
                        idx_n  = idx_inc;
                        stim_n = mem[idx_inc];
                        hc_n   = HC_INIT;
                    end
                end else begin
                    hc_n = hc - HW'(1);
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign bus.stim           = stim;
    assign bus.busy           = busy;
    assign bus.done           = done;
    assign bus.mismatch       = mis;
    assign bus.mismatch_idx   = midx;
    assign bus.mismatch_count = mcnt;
    assign bus.signature      = sig;
endmodule

// File: tb/tb_fuzz_vector_sequencer.sv
// Directed bench for fuzz_vector_sequencer with a stim scoreboard queue.
// Drives and samples on the falling edge; all expectations come from a model.
module tb_fuzz_vector_sequencer;
    localparam int VEC_W = 53;
    localparam int Y_W   = 82;
    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int HOLD  = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fuzz_vector_sequencer_if #(.VEC_W(VEC_W), .Y_W(Y_W), .AW(AW)) bus ();

    fuzz_vector_sequencer #(
        .VEC_W(VEC_W), .Y_W(Y_W), .DEPTH(DEPTH), .AW(AW), .HOLD(HOLD)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [VEC_W-1:0] tb_mem [DEPTH];
    logic [VEC_W-1:0] exp_q [$];
    logic [31:0]      m_sig;
    logic             m_mis;
    logic [AW-1:0]    m_idx;
    int               m_cnt;
    logic [31:0]      saved_sig;
    logic [Y_W-1:0]   ymix;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sig_next(input logic [31:0] s,
                                              input logic [Y_W-1:0] y);
        logic [31:0] f;
        f = y[31:0] ^ y[63:32] ^ {14'b0, y[81:64]};
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]} ^ f;
    endfunction

    function automatic logic [Y_W-1:0] yref_of(input int v,
                                                input logic [Y_W-1:0] yv,
                                                input bit mix);
        return mix ? (yv ^ Y_W'(tb_mem[v])) : yv;
    endfunction

    function automatic logic [Y_W-1:0] ydut_of(input int v, input int badv,
                                                input logic [Y_W-1:0] yv,
                                                input bit mix);
        return yref_of(v, yv, mix) ^ ((v == badv) ? Y_W'(1) : Y_W'(0));
    endfunction

    task automatic step(input int v, input int badv,
                        input logic [Y_W-1:0] yv, input bit mix);
        logic [Y_W-1:0] yr, yd;
        yr = yref_of(v, yv, mix);
        yd = ydut_of(v, badv, yv, mix);
        if (yr !== yd) begin
            if (!m_mis) begin
                m_mis = 1'b1;
                m_idx = AW'(v);
            end
            m_cnt++;
        end
        m_sig = sig_next(m_sig, yd);
    endtask

    task automatic write_all();
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            bus.cfg_we    = 1'b1;
            bus.cfg_addr  = AW'(i);
            bus.cfg_wdata = tb_mem[i];
        end
        @(negedge clk);
        bus.cfg_we = 1'b0;
    endtask

    task automatic run(input int num, input int badv,
                       input logic [Y_W-1:0] yv, input bit mix,
                       input bit poke);
        int n, k, v;
        n = (num > DEPTH) ? DEPTH : num;
        exp_q.delete();
        for (int h = 0; h < HOLD; h++) exp_q.push_back('0);
        for (int i = 0; i < n; i++)
            for (int h = 0; h < HOLD; h++) exp_q.push_back(tb_mem[i]);
        m_sig = '0;
        m_mis = 1'b0;
        m_idx = '0;
        m_cnt = 0;
        @(negedge clk);
        bus.cfg_num = (AW + 1)'(num);
        bus.start   = 1'b1;
        bus.y_ref   = yv;
        bus.y_dut   = yv;
        @(negedge clk);
        bus.start = 1'b0;
        k = 0;
        while (exp_q.size() > 0) begin
            chk("stim", bus.stim, exp_q.pop_front());
            chk("busy_run", bus.busy, 1'b1);
            if (k >= 2 * HOLD && k % HOLD == 0) begin
                step(k / HOLD - 2, badv, yv, mix);
                chk("sig_run", bus.signature, m_sig);
            end
            v = k / HOLD - 1;
            if (v >= 0 && v < n) begin
                bus.y_ref = yref_of(v, yv, mix);
                bus.y_dut = ydut_of(v, badv, yv, mix);
            end
            if (poke && k == HOLD + 1) begin
                bus.start     = 1'b1;
                bus.cfg_we    = 1'b1;
                bus.cfg_addr  = AW'(1);
                bus.cfg_wdata = ~tb_mem[1];
            end else begin
                bus.start  = 1'b0;
                bus.cfg_we = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        if (n > 0) step(n - 1, badv, yv, mix);
        chk("done", bus.done, 1'b1);
        chk("busy_end", bus.busy, 1'b0);
        chk("stim_end", bus.stim, '0);
        chk("mismatch", bus.mismatch, m_mis);
        chk("mismatch_idx", bus.mismatch_idx, m_idx);
        chk("mismatch_count", bus.mismatch_count, (AW + 1)'(m_cnt));
        chk("signature", bus.signature, m_sig);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.cfg_we    = 1'b0;
        bus.cfg_addr  = AW'(3);
        bus.cfg_wdata = VEC_W'(5);
        bus.cfg_num   = (AW + 1)'(5);
        bus.start     = 1'b1;
        bus.y_ref     = {Y_W{1'b1}};
        bus.y_dut     = Y_W'(7);
        #12;
        chk("rst_stim", bus.stim, '0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_mismatch", bus.mismatch, 1'b0);
        chk("rst_midx", bus.mismatch_idx, '0);
        chk("rst_mcnt", bus.mismatch_count, '0);
        chk("rst_sig", bus.signature, '0);
        bus.start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < DEPTH; i++)
            tb_mem[i] = {$urandom, $urandom};
        tb_mem[0] = VEC_W'(1);
        tb_mem[1] = VEC_W'(2);
        tb_mem[2] = VEC_W'(3);
        write_all();

        // empty run
        run(0, -1, '0, 1'b0, 1'b0);
        chk("empty_sig", bus.signature, 32'h0);

        // clean run
        run(3, -1, '0, 1'b0, 1'b0);
        chk("clean_sig", bus.signature, 32'h0);
        chk("clean_mis", bus.mismatch, 1'b0);

        // single mismatch on vector 1
        run(3, 1, '0, 1'b0, 1'b0);
        chk("one_mis", bus.mismatch, 1'b1);
        chk("one_idx", bus.mismatch_idx, AW'(1));
        chk("one_cnt", bus.mismatch_count, (AW + 1)'(1));

        // signature of a constant y
        run(2, -1, Y_W'(1), 1'b0, 1'b0);
        chk("sig_const", bus.signature, 32'h2);

        // start and cfg_we poked mid-run
        ymix = {18'h2_a5c3, $urandom, $urandom};
        run(3, -1, ymix, 1'b1, 1'b1);
        saved_sig = bus.signature;

        // oversized count with a mismatch deep in the list
        run(40, 17, ymix, 1'b1, 1'b0);
        chk("big_cnt", bus.mismatch_count, (AW + 1)'(1));

        // reset while mem[1] is applied
        @(negedge clk);
        bus.cfg_num = (AW + 1)'(3);
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 0; k < 2 * HOLD; k++) @(negedge clk);
        chk("pre_rst_stim", bus.stim, tb_mem[1]);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_stim", bus.stim, '0);
        chk("mid_rst_busy", bus.busy, 1'b0);
        chk("mid_rst_done", bus.done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        run(3, -1, ymix, 1'b1, 1'b0);
        chk("replay_sig", bus.signature, saved_sig);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
